// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the Nexys3 4-digit 7-segment scan controller.
// The glyph table is active-low gfedcba, indexed by hex nibble value.
package seg7_scan_ctrl_pkg;

    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Listed from F down to 0 so that GLYPH_TABLE[n] is the glyph of nibble n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph (gfedcba).
module seg7_hex_decode
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of four common-anode digits with a blanking gap before
// each digit and a frame-latched shadow copy of the displayed value.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int DRIVE_CYCLES = 45000,
    parameter int BLANK_CYCLES = 5000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] DRIVE_LAST = TIMER_W'(DRIVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);

    scan_state_t        state, state_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               load;

    logic [15:0] shadow_digits;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_en;
    logic [3:0]  cur_nibble;
    logic [6:0]  cur_glyph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // en=0 overrides everything, including a frame reload on the same edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        timer_nxt = timer + 1'b1;
        load      = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt   = 2'd0;
                timer_nxt = '0;
                if (en) begin
                    state_nxt = BLANK;
                    load      = 1'b1;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                    timer_nxt = '0;
                end else if (timer == BLANK_LAST) begin
                    state_nxt = DRIVE;
                    timer_nxt = '0;
                end
            end
            DRIVE: begin
                if (!en) begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                    timer_nxt = '0;
                end else if (timer == DRIVE_LAST) begin
                    state_nxt = BLANK;
                    timer_nxt = '0;
                    if (idx == 2'd3) begin
                        idx_nxt = 2'd0;
                        load    = 1'b1;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 2'd0;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= 2'd0;
            timer         <= '0;
            frame_tick    <= 1'b0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_en     <= '0;
        end else begin
            idx        <= idx_nxt;
            timer      <= timer_nxt;
            frame_tick <= load;
            if (load) begin
                shadow_digits <= digits;
                shadow_dp     <= dp;
                shadow_en     <= digit_en;
            end
        end
    end

    assign cur_nibble = shadow_digits[{idx, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    // an/seg are decoded from the current state, so they trail it by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= ANODE_OFF;
            seg <= SEG_OFF;
        end else if (state == DRIVE && shadow_en[idx]) begin
            an  <= ~(4'b0001 << idx);
            seg <= {~shadow_dp[idx], cur_glyph};
        end else begin
            an  <= ANODE_OFF;
            seg <= SEG_OFF;
        end
    end

endmodule
